queue_ctrl: RTL and testbench

Push/pop control and storage stage of the hardware queue. Accepts writes and reads through a valid-style handshake and holds the data in an internal circular buffer. Maintains full/empty/threshold flags and sticky error flags. Drives the enable/direction pair consumed by the 11-bit up/down occupancy counter stage directly downstream, so that counter tracks queue level in lockstep with this block's pointers.

---
 rtl/queue_ctrl.sv | 76 +++++++
 tb/tb_queue_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/queue_ctrl.sv
// Push/pop control and storage for the hardware queue: circular buffer, level shadow,
// status/sticky error flags and the enable/direction drive for the downstream occupancy counter.
module queue_ctrl #(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 10,
  parameter int CNT_W    = 11,
  parameter int AF_LEVEL = 1020,
  parameter int AE_LEVEL = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CNT_W-1:0] level,
  output logic             ovf_err,
  output logic             udf_err,
  output logic             cnt_en,
  output logic             cnt_dir
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_L    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_L    = CNT_W'(AE_LEVEL);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              push_acc, pop_acc;

  // No bypass: an empty queue never accepts a pop, even alongside a push.
  assign pop_acc  = pop & ~empty;
  assign push_acc = push & (~full | pop_acc);

  assign full         = (level == DEPTH_L);
  assign empty        = (level == '0);
  assign almost_full  = (level >= AF_L);
  assign almost_empty = (level <= AE_L);

  // The downstream counter must see nothing while reset is held.
  assign cnt_en  = reset_n & (push_acc ^ pop_acc);
  assign cnt_dir = reset_n & pop_acc & ~push_acc;

  // Storage is not reset; a push in a reset cycle is discarded.
  always_ff @(posedge clk) begin
    if (reset_n && push_acc) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ovf_err    <= 1'b0;
      udf_err    <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_acc) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
        dout   <= mem[rd_ptr];  // old word on simultaneous full push+pop
      end
      dout_valid <= pop_acc;
      if (push_acc && !pop_acc)      level <= level + CNT_W'(1);
      else if (pop_acc && !push_acc) level <= level - CNT_W'(1);
      if (push && !push_acc) ovf_err <= 1'b1;
      if (pop && !pop_acc)   udf_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_queue_ctrl.sv
// Randomized self-checking bench for queue_ctrl against a queue-based reference model
// plus a behavioural model of the downstream 11-bit up/down occupancy counter.
module tb_queue_ctrl;
  logic       clk = 1'b0;
  logic       reset_n, push, pop;
  logic [7:0] din, dout;
  logic       dout_valid, full, empty, almost_full, almost_empty;
  logic [10:0] level;
  logic       ovf_err, udf_err, cnt_en, cnt_dir;

  queue_ctrl dut (
    .clk(clk), .reset_n(reset_n), .push(push), .din(din), .pop(pop),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .ovf_err(ovf_err), .udf_err(udf_err), .cnt_en(cnt_en), .cnt_dir(cnt_dir)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // reference model state
  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_dv, m_ovf, m_udf, exp_en, exp_dir, obs_en, obs_dir;
  int         qout;  // downstream counter driven by the DUT's cnt_en/cnt_dir

  // One clock: drive inputs, capture combinational counter drive, advance model.
  task automatic cycle(input logic p, input logic r, input logic [7:0] d, input logic rs);
    logic pa, wa;
    reset_n = rs; push = p; pop = r; din = d;
    #1;
    obs_en = cnt_en; obs_dir = cnt_dir;
    if (!rs) begin
      q.delete(); m_dout = 8'h00; m_dv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      exp_en = 1'b0; exp_dir = 1'b0;
    end else begin
      pa = r && (q.size() > 0);
      wa = p && ((q.size() < 1024) || pa);
      m_dv = pa;
      if (pa) m_dout = q.pop_front();
      if (wa) q.push_back(d);
      if (p && !wa) m_ovf = 1'b1;
      if (r && !pa) m_udf = 1'b1;
      exp_en = pa ^ wa; exp_dir = pa & ~wa;
    end
    @(posedge clk);
    if (!rs) qout = 0;
    else if (obs_en) qout = obs_dir ? (qout + 2047) % 2048 : (qout + 1) % 2048;
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    n_chk++; if (level !== 11'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
    n_chk++; if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin n_fail++; $display("FAIL reset_flags got %b want 1100", {empty, almost_empty, full, almost_full}); end
    n_chk++; if ({dout_valid, ovf_err, udf_err} !== 3'b000) begin n_fail++; $display("FAIL reset_status got %b want 000", {dout_valid, ovf_err, udf_err}); end
    n_chk++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h want 00", dout); end
    n_chk++; if (obs_en !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_en got %b want 0", obs_en); end
  endtask

  task automatic test_basic();
    logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    int lv [6] = '{1, 2, 3, 2, 1, 0};
    for (int i = 0; i < 6; i++) begin
      if (i < 3) cycle(1'b1, 1'b0, vals[i], 1'b1);
      else       cycle(1'b0, 1'b1, 8'h00, 1'b1);
      n_chk++; if (level !== 11'(lv[i])) begin n_fail++; $display("FAIL basic_level step %0d got %0d want %0d", i, level, lv[i]); end
      if (i >= 3) begin
        n_chk++; if (dout_valid !== 1'b1 || dout !== vals[i-3]) begin n_fail++; $display("FAIL basic_dout step %0d got %b/%h want 1/%h", i, dout_valid, dout, vals[i-3]); end
      end
    end
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty got %b want 1", empty); end
  endtask

  task automatic test_fill();
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 1024; i++) begin
      cycle(1'b1, 1'b0, 8'(i), 1'b1);
      n_chk++; if (level !== 11'(q.size()) || almost_full !== (q.size() >= 1020) || full !== (q.size() == 1024) || almost_empty !== (q.size() <= 4))
        begin n_fail++; $display("FAIL fill_flags i=%0d got lvl %0d af %b f %b ae %b want lvl %0d", i, level, almost_full, full, almost_empty, q.size()); end
    end
    n_chk++; if (full !== 1'b1 || ovf_err !== 1'b0) begin n_fail++; $display("FAIL fill_full got f %b ovf %b want 1 0", full, ovf_err); end
    cycle(1'b1, 1'b0, 8'hEE, 1'b1);
    n_chk++; if (ovf_err !== 1'b1 || level !== 11'd1024) begin n_fail++; $display("FAIL fill_ovf got ovf %b lvl %0d want 1 1024", ovf_err, level); end
    n_chk++; if (obs_en !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_cnt_en got %b want 0", obs_en); end
  endtask

  task automatic test_full_pushpop();
    cycle(1'b1, 1'b1, 8'hAA, 1'b1);
    n_chk++; if (dout !== 8'h00 || dout_valid !== 1'b1) begin n_fail++; $display("FAIL full_pp_dout got %b/%h want 1/00", dout_valid, dout); end
    n_chk++; if (level !== 11'd1024 || obs_en !== 1'b0) begin n_fail++; $display("FAIL full_pp_level got %0d en %b want 1024 0", level, obs_en); end
    for (int i = 0; i < 1024; i++) begin
      cycle(1'b0, 1'b1, 8'h00, 1'b1);
      n_chk++; if (dout !== m_dout || dout_valid !== 1'b1 || level !== 11'(q.size()))
        begin n_fail++; $display("FAIL drain i=%0d got %h lvl %0d want %h lvl %0d", i, dout, level, m_dout, q.size()); end
    end
    n_chk++; if (dout !== 8'hAA || empty !== 1'b1) begin n_fail++; $display("FAIL drain_last got %h empty %b want AA 1", dout, empty); end
  endtask

  task automatic test_empty_pushpop();
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 8'h5A, 1'b1);
    n_chk++; if (level !== 11'd1 || udf_err !== 1'b1 || dout_valid !== 1'b0)
      begin n_fail++; $display("FAIL empty_pp got lvl %0d udf %b dv %b want 1 1 0", level, udf_err, dout_valid); end
    n_chk++; if (obs_en !== 1'b1 || obs_dir !== 1'b0) begin n_fail++; $display("FAIL empty_pp_cnt got en %b dir %b want 1 0", obs_en, obs_dir); end
    cycle(1'b0, 1'b1, 8'h00, 1'b1);
    n_chk++; if (dout !== 8'h5A || dout_valid !== 1'b1) begin n_fail++; $display("FAIL empty_pp_pop got %b/%h want 1/5a", dout_valid, dout); end
  endtask

  task automatic test_random();
    int pushed = 0, cyc = 0, bad = 0;
    logic p, r;
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    while (pushed < 3000 && cyc < 20000) begin
      p = ($urandom_range(99) < 55);
      r = ($urandom_range(99) < 50);
      if (p && (q.size() < 1024 || (r && q.size() > 0))) pushed++;
      cycle(p, r, 8'($urandom), 1'b1);
      cyc++;
      n_chk++;
      if (level !== 11'(q.size()) || qout != q.size() || obs_en !== exp_en || obs_dir !== exp_dir ||
          dout_valid !== m_dv || dout !== m_dout || ovf_err !== m_ovf || udf_err !== m_udf ||
          empty !== (q.size() == 0) || full !== (q.size() == 1024)) begin
        n_fail++;
        if (bad < 10) $display("FAIL random cyc %0d got lvl %0d cnt %0d en %b dir %b dv %b dout %h ovf %b udf %b want lvl %0d en %b dir %b dv %b dout %h ovf %b udf %b",
          cyc, level, qout, obs_en, obs_dir, dout_valid, dout, ovf_err, udf_err, q.size(), exp_en, exp_dir, m_dv, m_dout, m_ovf, m_udf);
        bad++;
      end
    end
    n_chk++; if (pushed < 3000) begin n_fail++; $display("FAIL random_budget got %0d pushes want 3000", pushed); end
  endtask

  task automatic test_mid_reset();
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 500; i++) cycle(1'b1, 1'b0, 8'(i * 3), 1'b1);
    n_chk++; if (level !== 11'd500 || udf_err !== 1'b1 || qout != 500) begin n_fail++; $display("FAIL midrst_pre got lvl %0d udf %b cnt %0d want 500 1 500", level, udf_err, qout); end
    cycle(1'b1, 1'b1, 8'h77, 1'b0);
    n_chk++; if (obs_en !== 1'b0) begin n_fail++; $display("FAIL midrst_cnt_en got %b want 0", obs_en); end
    n_chk++; if (level !== 11'd0 || empty !== 1'b1 || qout != 0) begin n_fail++; $display("FAIL midrst_level got lvl %0d empty %b cnt %0d want 0 1 0", level, empty, qout); end
    n_chk++; if ({ovf_err, udf_err, dout_valid} !== 3'b000) begin n_fail++; $display("FAIL midrst_status got %b want 000", {ovf_err, udf_err, dout_valid}); end
    cycle(1'b0, 1'b1, 8'h00, 1'b1);
    n_chk++; if (udf_err !== 1'b1 || dout_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_discard got udf %b dv %b want 1 0", udf_err, dout_valid); end
  endtask

  initial begin
    reset_n = 1'b0; push = 1'b0; pop = 1'b0; din = 8'h00; qout = 0;
    m_dout = 8'h00; m_dv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; exp_en = 1'b0; exp_dir = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_fill();
    test_full_pushpop();
    test_empty_pushpop();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
